masked_dot_product: RTL

- Sequential masked multiply-accumulate stage that sits directly upstream of the ReLU stage in the garbled secure-inference datapath.
- Each beat reconstructs one secret activation from its evaluator share and garbler mask, multiplies it by a garbler-held weight, and accumulates the product.
- After K beats it emits the dot product re-masked as (acc - r_out) mod 2^N. This output is exactly the evaluator-side input the ReLU stage consumes, with r_out equal to that stage's r_1 mask.

---
 rtl/masked_dot_product.sv | 80 ++++++++
 1 files changed

// File: rtl/masked_dot_product.sv
// Masked multiply-accumulate: reconstructs x_i = e_i + r_in_i, accumulates w_i * x_i over K beats,
// and emits (sum - r_out) mod 2^N. Define MAC_FIXED_POINT_EN for a Q(N-F).F product (>>> F).
module masked_dot_product #(
    parameter int N = 32,
    parameter int K = 16,
    parameter int F = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [3*N-1:0] g_input,
    input  logic [N-1:0]   e_input,
    input  logic           in_valid,
    output logic [N-1:0]   o,
    output logic           o_valid
);

    localparam int CW = (K > 1) ? $clog2(K) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(K - 1);

    logic [N-1:0]  w_i, r_in_i, r_out, x_i, p_i, acc_sum;
    logic [N-1:0]  acc_d, acc_q, o_d, o_q;
    logic [CW-1:0] cnt_d, cnt_q;
    logic          o_valid_d, o_valid_q;

    assign w_i    = g_input[3*N-1:2*N];
    assign r_in_i = g_input[2*N-1:N];
    assign r_out  = g_input[N-1:0];

    // Unmasking is a plain modular add; the carry-out carries no information.
    assign x_i = e_input + r_in_i;

`ifdef MAC_FIXED_POINT_EN
    // Only the low N+F bits of the signed product survive the shift and truncation.
    logic signed [N+F-1:0] prod_full;
    assign prod_full = $signed(w_i) * $signed(x_i);
    assign p_i       = N'(prod_full >>> F);
`else
    assign p_i = w_i * x_i;
`endif

    assign acc_sum = acc_q + p_i;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        o_d       = o_q;
        o_valid_d = 1'b0;
        if (in_valid) begin
            if (cnt_q == LAST_BEAT) begin
                o_d       = acc_sum - r_out;
                o_valid_d = 1'b1;
                acc_d     = '0;
                cnt_d     = '0;
            end else begin
                acc_d = acc_sum;
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state flops use non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            acc_q     <= '0;
            cnt_q     <= '0;
            o_q       <= '0;
            o_valid_q <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            o_q       <= o_d;
            o_valid_q <= o_valid_d;
        end
    end

    assign o       = o_q;
    assign o_valid = o_valid_q;

endmodule
